cacheline_adaptor: RTL and testbench
====================================

// Module: cacheline_adaptor
// PURPOSE
//  Sits between the cache datapath/control and physical memory.
//  Cache side: one 256-bit line per request. Memory side: a burst of 64-bit beats.
//  Serialises write-backs into beats; assembles read beats into one line.
//  Returns a single-cycle response to the cache controller on completion.
// PARAMETERS
//  s_line   256  cache line width in bits
//  s_burst  64   memory beat width in bits; BEATS = s_line/s_burst (4); must divide exactly
//  TIMEOUT  64   watchdog limit in cycles (used only with CACHELINE_ADAPTOR_TIMEOUT_EN)
// PORTS
//  clk        in   1        clock, all state on rising edge
//  rst        in   1        asynchronous, active-high reset
//  line_i     in   s_line   write-back line from cache (pmem_wdata)
//  line_o     out  s_line   assembled fill line to cache (pmem_rdata)
//  address_i  in   32       line address from cache (pmem_address)
//  read_i     in   1        cache requests line fill; held until resp_o
//  write_i    in   1        cache requests write-back; held until resp_o
//  resp_o     out  1        one-cycle completion pulse to cache
//  burst_i    in   s_burst  read beat from memory
//  burst_o    out  s_burst  write beat to memory
//  address_o  out  32       line-aligned burst address to memory
//  read_o     out  1        burst read request to memory
//  write_o    out  1        burst write request to memory
//  resp_i     in   1        memory beat strobe; one beat per high cycle
//  err_o      out  1        watchdog error pulse (tied 0 when feature disabled)
// BEHAVIOUR
//  Reset (async): state=IDLE; beat counter=0; line_o, burst_o, address_o = 0;
//   read_o, write_o, resp_o, err_o = 0. Reset mid-burst abandons the burst; no resp_o.
//  States: IDLE -> RD_BURST | WR_BURST -> DONE -> IDLE. All outputs registered.
//  IDLE: on write_i, latch line_i and {address_i[31:5],5'b0}; next cycle write_o=1 (WR_BURST).
//   Otherwise on read_i, latch address; next cycle read_o=1 (RD_BURST).
//   read_i and write_i together: write wins; the read is served on a later request.
//  RD_BURST: read_o and address_o held. Each cycle resp_i=1, burst_i is stored into
//   line_o[s_burst*cnt +: s_burst] and cnt increments (beat 0 = bits 63:0).
//   resp_i=0 cycles stall without advancing. After beat BEATS-1, read_o drops that
//   edge -> DONE.
//  WR_BURST: write_o held; burst_o = latched_line[s_burst*cnt +: s_burst], valid while
//   write_o=1. Each resp_i=1 consumes the beat and advances cnt.
//   After beat BEATS-1, write_o drops -> DONE.
//  DONE: resp_o=1 for exactly one cycle -> IDLE. line_o holds until the next fill begins.
//  The cache must drop read_i/write_i the cycle after resp_o; IDLE ignores requests
//   during the DONE cycle.
//  Counter: $clog2(BEATS) bits. Wraps to 0 on the last beat. Cleared on entry to any burst.
//  resp_i in IDLE/DONE is ignored. Latency: fill = 2 + BEATS + stall cycles, request to resp_o.
//  Latched address/line are frozen for the whole burst; input changes mid-burst are ignored.
// CONFIGURATION
//  CACHELINE_ADAPTOR_TIMEOUT_EN defined: cycle counter runs in RD_BURST/WR_BURST and
//   resets on each resp_i. Reaching TIMEOUT cycles with no resp_i: read_o/write_o drop,
//   err_o pulses 1 cycle, resp_o pulses the same cycle, state -> IDLE; line_o partial.
//  Not defined: no watchdog; bursts wait on resp_i indefinitely; err_o tied 0.
// TESTING
//  Fill: read_i, addr 0x0000_1234; beats 0x11..11,0x22..22,0x33..33,0x44..44 on consecutive
//   resp_i -> address_o=0x0000_1220; line_o={44..,33..,22..,11..}; one resp_o pulse.
//  Write-back: write_i, line_i={D,C,B,A} -> burst_o A,B,C,D in order; write_o drops after D;
//   resp_o pulses once.
//  Stall: fill with resp_i gaps of 3 idle cycles between beats -> identical line_o;
//   resp_o count=1.
//  Simultaneous read_i+write_i -> write_o asserted, read_o stays 0 until the write completes.
//  rst asserted after 2 read beats -> all outputs 0 immediately; no resp_o;
//   a new fill then completes correctly.
//  TIMEOUT_EN, TIMEOUT=64, no resp_i -> err_o and resp_o pulse at cycle 64; read_o=0 after.

Source files
------------

// File: rtl/cacheline_adaptor.sv
// Cache line <-> memory burst adaptor: splits 256-bit write-backs into 64-bit beats
// and assembles 64-bit read beats into one line, answering the cache with one resp_o pulse.
//
// Ports:
//   clk, rst (async, active-high)
//   cache side : line_i, line_o, address_i, read_i, write_i, resp_o
//   memory side: burst_i, burst_o, address_o, read_o, write_o, resp_i
//   err_o      : watchdog error pulse
//
// Optional feature: define CACHELINE_ADAPTOR_TIMEOUT_EN to enable a burst watchdog
// (TIMEOUT cycles without resp_i aborts the burst). Without it, err_o is tied 0.

module cacheline_adaptor #(
    parameter int s_line  = 256,
    parameter int s_burst = 64,
    parameter int TIMEOUT = 64
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [s_line-1:0]  line_i,
    output logic [s_line-1:0]  line_o,
    input  logic [31:0]        address_i,
    input  logic               read_i,
    input  logic               write_i,
    output logic               resp_o,
    input  logic [s_burst-1:0] burst_i,
    output logic [s_burst-1:0] burst_o,
    output logic [31:0]        address_o,
    output logic               read_o,
    output logic               write_o,
    input  logic               resp_i,
    output logic               err_o
);

    localparam int BEATS = s_line / s_burst;
    localparam int CW    = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int OFS   = $clog2(s_line / 8);
    localparam logic [CW-1:0] LAST = CW'(BEATS - 1);

    typedef enum logic [1:0] {
        IDLE,
        RD_BURST,
        WR_BURST,
        DONE
    } state_t;

    state_t             state_q, state_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [CW-1:0]      cnt_nxt;
    logic [s_line-1:0]  line_q, line_d;
    logic [s_line-1:0]  wbuf_q, wbuf_d;
    logic [s_burst-1:0] burst_q, burst_d;
    logic [31:0]        addr_q, addr_d;
    logic               rd_q, rd_d;
    logic               wr_q, wr_d;
    logic               resp_q, resp_d;

`ifdef CACHELINE_ADAPTOR_TIMEOUT_EN
    localparam int WW = $clog2(TIMEOUT + 1);
    logic [WW-1:0] wd_q, wd_d;
    logic          err_q, err_d;
`endif

    // Wraps to 0 after the last beat.
    assign cnt_nxt = cnt_q + 1'b1;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        line_d  = line_q;
        wbuf_d  = wbuf_q;
        burst_d = burst_q;
        addr_d  = addr_q;
        rd_d    = rd_q;
        wr_d    = wr_q;
        resp_d  = 1'b0;

        unique case (state_q)
            IDLE: begin
                // Write-back has priority; a pending read is picked up later.
                if (write_i) begin
                    wbuf_d  = line_i;
                    burst_d = line_i[s_burst-1:0];
                    addr_d  = {address_i[31:OFS], {OFS{1'b0}}};
                    cnt_d   = '0;
                    wr_d    = 1'b1;
                    state_d = WR_BURST;
                end else if (read_i) begin
                    addr_d  = {address_i[31:OFS], {OFS{1'b0}}};
                    cnt_d   = '0;
                    rd_d    = 1'b1;
                    state_d = RD_BURST;
                end
            end
            RD_BURST: begin
                if (resp_i) begin
                    line_d[s_burst*int'(cnt_q) +: s_burst] = burst_i;
                    cnt_d = cnt_nxt;
                    if (cnt_q == LAST) begin
                        rd_d    = 1'b0;
                        resp_d  = 1'b1;
                        state_d = DONE;
                    end
                end
            end
            WR_BURST: begin
                if (resp_i) begin
                    // Pre-load the next beat so burst_o stays a register.
                    burst_d = wbuf_q[s_burst*int'(cnt_nxt) +: s_burst];
                    cnt_d   = cnt_nxt;
                    if (cnt_q == LAST) begin
                        wr_d    = 1'b0;
                        resp_d  = 1'b1;
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                // Requests still held this cycle are ignored.
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

`ifdef CACHELINE_ADAPTOR_TIMEOUT_EN
        wd_d  = '0;
        err_d = 1'b0;
        if (state_q == RD_BURST || state_q == WR_BURST) begin
            if (resp_i) begin
                wd_d = '0;
            end else if (wd_q == WW'(TIMEOUT - 1)) begin
                // Abort: line_o keeps whatever beats arrived.
                rd_d    = 1'b0;
                wr_d    = 1'b0;
                resp_d  = 1'b1;
                err_d   = 1'b1;
                state_d = IDLE;
            end else begin
                wd_d = wd_q + 1'b1;
            end
        end
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            line_q  <= '0;
            wbuf_q  <= '0;
            burst_q <= '0;
            addr_q  <= '0;
            rd_q    <= 1'b0;
            wr_q    <= 1'b0;
            resp_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            line_q  <= line_d;
            wbuf_q  <= wbuf_d;
            burst_q <= burst_d;
            addr_q  <= addr_d;
            rd_q    <= rd_d;
            wr_q    <= wr_d;
            resp_q  <= resp_d;
        end
    end

`ifdef CACHELINE_ADAPTOR_TIMEOUT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wd_q  <= '0;
            err_q <= 1'b0;
        end else begin
            wd_q  <= wd_d;
            err_q <= err_d;
        end
    end

    assign err_o = err_q;
`else
    assign err_o = 1'b0;
`endif

    assign line_o    = line_q;
    assign burst_o   = burst_q;
    assign address_o = addr_q;
    assign read_o    = rd_q;
    assign write_o   = wr_q;
    assign resp_o    = resp_q;

endmodule

// File: tb/tb_cacheline_adaptor.sv
// Directed testbench for cacheline_adaptor: table of fills/write-backs
// plus sequences for priority, mid-burst reset and the watchdog.

module tb_cacheline_adaptor;

    logic         clk = 1'b0;
    logic         rst;
    logic [255:0] line_i, line_o;
    logic [31:0]  address_i, address_o;
    logic         read_i, write_i, resp_o;
    logic [63:0]  burst_i, burst_o;
    logic         read_o, write_o, resp_i, err_o;

    cacheline_adaptor dut (
        .clk      (clk),
        .rst      (rst),
        .line_i   (line_i),
        .line_o   (line_o),
        .address_i(address_i),
        .read_i   (read_i),
        .write_i  (write_i),
        .resp_o   (resp_o),
        .burst_i  (burst_i),
        .burst_o  (burst_o),
        .address_o(address_o),
        .read_o   (read_o),
        .write_o  (write_o),
        .resp_i   (resp_i),
        .err_o    (err_o)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_fail = 0;
    int resp_cnt = 0;

    always @(posedge clk) if (resp_o === 1'b1) resp_cnt++;

    typedef struct {
        logic         wr;
        logic [31:0]  addr;
        logic [255:0] data;
        int           gap;
        logic [31:0]  exp_addr;
    } vec_t;

    vec_t tbl[5];

    task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick;
        @(negedge clk);
    endtask

    // Expects read_o high at the current negedge.
    task automatic fill_beats(input logic [255:0] d, input int gap);
        for (int b = 0; b < 4; b++) begin
            for (int g = 0; g < gap; g++) begin
                resp_i = 1'b0;
                tick;
                chk("fill read_o held", read_o, 1'b1);
            end
            resp_i  = 1'b1;
            burst_i = d[64*b +: 64];
            tick;
        end
        resp_i  = 1'b0;
        burst_i = '0;
        chk("fill resp_o", resp_o, 1'b1);
        chk("fill read_o drop", read_o, 1'b0);
        read_i = 1'b0;
    endtask

    // Expects write_o high at the current negedge.
    task automatic write_beats(input logic [255:0] d, input int gap);
        for (int b = 0; b < 4; b++) begin
            for (int g = 0; g < gap; g++) begin
                resp_i = 1'b0;
                tick;
            end
            chk("wr burst_o", burst_o, d[64*b +: 64]);
            chk("wr write_o", write_o, 1'b1);
            resp_i = 1'b1;
            tick;
        end
        resp_i = 1'b0;
        chk("wr resp_o", resp_o, 1'b1);
        chk("wr write_o drop", write_o, 1'b0);
        chk("wr read_o low", read_o, 1'b0);
        write_i = 1'b0;
    endtask

    task automatic run_vec(input vec_t v);
        int c0;
        c0 = resp_cnt;
        address_i = v.addr;
        line_i    = v.data;
        if (v.wr) write_i = 1'b1;
        else      read_i  = 1'b1;
        tick;
        // Inputs must be frozen once the burst starts.
        address_i = ~v.addr;
        line_i    = ~v.data;
        chk("address_o", address_o, v.exp_addr);
        chk("read_o start", read_o, !v.wr);
        chk("write_o start", write_o, v.wr);
        if (v.wr) write_beats(v.data, v.gap);
        else      fill_beats(v.data, v.gap);
        tick;
        chk("resp_o one cycle", resp_o, 1'b0);
        tick;
        chk("resp_o count", resp_cnt, c0 + 1);
        if (!v.wr) chk("line_o", line_o, v.data);
    endtask

    logic [255:0] L1, L2, L3, L4;
    logic         ok;
    int           c0;

    initial begin
        L1 = {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
              64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111};
        L2 = {64'hDDDD_DDDD_DDDD_DDDD, 64'hCCCC_CCCC_CCCC_CCCC,
              64'hBBBB_BBBB_BBBB_BBBB, 64'hAAAA_AAAA_AAAA_AAAA};
        L3 = {64'h0123_4567_89AB_CDEF, 64'hFEDC_BA98_7654_3210,
              64'h8000_0000_0000_0001, 64'h7FFF_FFFF_FFFF_FFFE};
        L4 = {64'hA5A5_0000_5A5A_FFFF, 64'h0000_0000_0000_0000,
              64'hFFFF_FFFF_FFFF_FFFF, 64'h1357_9BDF_2468_ACE0};

        tbl[0] = '{1'b0, 32'h0000_1234, L1, 0, 32'h0000_1220};
        tbl[1] = '{1'b1, 32'hDEAD_BEEF, L2, 0, 32'hDEAD_BEE0};
        tbl[2] = '{1'b0, 32'h0000_1234, L1, 3, 32'h0000_1220};
        tbl[3] = '{1'b1, 32'hFFFF_FFFF, L3, 2, 32'hFFFF_FFE0};
        tbl[4] = '{1'b0, 32'h0000_001F, L4, 1, 32'h0000_0000};

        rst = 1'b1;
        line_i = '0; address_i = '0; read_i = 1'b0; write_i = 1'b0;
        burst_i = '0; resp_i = 1'b0;
        tick;
        tick;
        chk("rst line_o", line_o, '0);
        chk("rst burst_o", burst_o, '0);
        chk("rst address_o", address_o, '0);
        chk("rst read_o", read_o, 1'b0);
        chk("rst write_o", write_o, 1'b0);
        chk("rst resp_o", resp_o, 1'b0);
        chk("rst err_o", err_o, 1'b0);
        rst = 1'b0;
        tick;

        for (int i = 0; i < 5; i++) run_vec(tbl[i]);

        // Read and write together: write first, read served afterwards.
        c0 = resp_cnt;
        address_i = 32'h0000_0040;
        line_i    = L3;
        read_i    = 1'b1;
        write_i   = 1'b1;
        tick;
        chk("both write_o", write_o, 1'b1);
        chk("both read_o", read_o, 1'b0);
        write_beats(L3, 0);
        tick;
        chk("both read_o idle", read_o, 1'b0);
        tick;
        chk("both read_o later", read_o, 1'b1);
        fill_beats(L2, 0);
        tick;
        tick;
        chk("both resp count", resp_cnt, c0 + 2);
        chk("both line_o", line_o, L2);

        // Reset after two beats of a fill.
        address_i = 32'h0000_2000;
        read_i    = 1'b1;
        tick;
        for (int b = 0; b < 2; b++) begin
            resp_i  = 1'b1;
            burst_i = L4[64*b +: 64];
            tick;
        end
        resp_i = 1'b0;
        c0 = resp_cnt;
        #1 rst = 1'b1;
        #1;
        chk("mid rst outputs",
            {read_o, write_o, resp_o, err_o, address_o, burst_o}, '0);
        chk("mid rst line_o", line_o, '0);
        read_i = 1'b0;
        tick;
        rst = 1'b0;
        tick;
        tick;
        chk("mid rst no resp", resp_cnt, c0);
        run_vec(tbl[0]);

        // Long stall with no beats.
        c0 = resp_cnt;
        address_i = 32'h0000_3000;
        read_i    = 1'b1;
        tick;
        chk("stall read_o", read_o, 1'b1);
`ifdef CACHELINE_ADAPTOR_TIMEOUT_EN
        ok = 1'b1;
        for (int i = 1; i < 64; i++) begin
            tick;
            if (read_o !== 1'b1 || err_o !== 1'b0) ok = 1'b0;
        end
        chk("wd waiting", ok, 1'b1);
        tick;
        chk("wd err_o", err_o, 1'b1);
        chk("wd resp_o", resp_o, 1'b1);
        chk("wd read_o", read_o, 1'b0);
        read_i = 1'b0;
        tick;
        chk("wd err pulse", err_o, 1'b0);
        chk("wd read_o after", read_o, 1'b0);
        tick;
        chk("wd resp count", resp_cnt, c0 + 1);
`else
        ok = 1'b1;
        for (int i = 0; i < 100; i++) begin
            tick;
            if (read_o !== 1'b1 || err_o !== 1'b0 || resp_o !== 1'b0) ok = 1'b0;
        end
        chk("stall waiting", ok, 1'b1);
        chk("stall no resp", resp_cnt, c0);
        fill_beats(L3, 0);
        tick;
        tick;
        chk("stall line_o", line_o, L3);
        chk("stall resp count", resp_cnt, c0 + 1);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
